uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the CPU data bus, in parallel with progmem; consumes the same mem_addr/mem_wdata/mem_wstrb/mem_rstrb the CPU drives.
- CPU stores bytes into a small TX FIFO and polls a status word; a serializer drives 8N1 frames on uart_txd.
- Top ORs/muxes its mem_rdata with progmem's, selected by the IO address bit.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_tx_mmio.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// UART_PARITY_EN selects whether the PARITY state is used by uart_tx_mmio.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } tx_state_e;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; dout shows the head entry combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and polled STATUS word.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4,
  parameter int IO_ADDR_BIT  = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        uart_txd
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef UART_PARITY_EN
  logic        par_q, par_d;
`endif

  logic        sel, wr_cyc, push, pop, busy, baud_last;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [1:0]  off;
  logic [31:0] status;
  logic        unused_bits;

  assign sel         = mem_addr[IO_ADDR_BIT];
  assign off         = mem_addr[3:2];
  assign wr_cyc      = sel && (mem_wstrb != '0);
  assign push        = wr_cyc && (off == OFF_DATA) && mem_wstrb[0];
  assign busy        = (state_q != IDLE);
  assign baud_last   = (baud_q == BAUD_LAST);
  assign unused_bits = ^{mem_addr, mem_wdata};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (mem_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = busy;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVF]   = ovf_q;

    rdata_d = rdata_q;
    if (mem_rstrb) rdata_d = (sel && off == OFF_STATUS) ? status : '0;

    // Drop-and-flag beats the software clear when both land together.
    ovf_d = ovf_q;
    if (wr_cyc && off == OFF_STATUS && mem_wdata[ST_OVF]) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
`ifdef UART_PARITY_EN
          par_d   = even_parity(fifo_dout);
`endif
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else baud_d = baud_q + BW'(1);
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else bit_d = bit_q + 3'd1;
        end else baud_d = baud_q + BW'(1);
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = STOP;
        end else baud_d = baud_q + BW'(1);
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else baud_d = baud_q + BW'(1);
      end
      default: state_d = IDLE;
    endcase

    // txd is registered from the next state so the line changes with the state flop.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign mem_rdata = rdata_q;
  assign uart_txd  = txd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: queued bytes are checked against decoded frames.
module tb_uart_tx_mmio;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam logic [31:0] IO       = 32'h0040_0000;
  localparam logic [31:0] DATA_A   = IO | 32'h0;
  localparam logic [31:0] STATUS_A = IO | 32'h4;
  localparam logic [31:0] OFF2_A   = IO | 32'h8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rstrb, uart_txd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .IO_ADDR_BIT  (22)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .uart_txd  (uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    @(posedge clk);
    #1;
    mem_wstrb = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_addr  = a;
    mem_rstrb = 1'b1;
    @(posedge clk);
    #1;
    mem_rstrb = 1'b0;
    d = mem_rdata;
  endtask

  // Frame monitor: samples every cycle, decodes one slot per CPB cycles
  logic [NSLOT-1:0] mbits;
  logic             mstable;
  logic [7:0]       mdata, mexp;
  int               mstart, mprev;
  bit               mprev_ok = 1'b0;
  bit               mon_busy = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_txd === 1'b0) begin
        mon_busy = 1'b1;
        mstable  = 1'b1;
        mstart   = cyc;
        if (mprev_ok && (mstart - mprev) <= NSLOT*CPB + 4)
          check_eq("frame_gap", mstart - mprev, NSLOT*CPB + 1);
        for (int s = 0; s < NSLOT; s++) begin
          for (int c = 0; c < CPB; c++) begin
            if (s != 0 || c != 0) @(negedge clk);
            if (c == 0) mbits[s] = uart_txd;
            else if (uart_txd !== mbits[s]) mstable = 1'b0;
          end
        end
        mdata = mbits[8:1];
        check_eq("start_bit", mbits[0], 0);
        check_eq("bit_stable", mstable, 1);
        check_eq("stop_bit", mbits[NSLOT-1], 1);
        if (exp_q.size() == 0) begin
          check_eq("spurious_frame", {24'h0, mdata}, 32'hFFFF_FFFF);
        end else begin
          mexp = exp_q.pop_front();
          check_eq("rx_byte", mdata, mexp);
`ifdef UART_PARITY_EN
          check_eq("parity_bit", mbits[9], ^mexp);
`endif
        end
        mprev    = mstart;
        mprev_ok = 1'b1;
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_timeout", n < 3000, 1);
    tick(2);
  endtask

  logic [31:0] v;

  initial begin
    rst       = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    mem_rstrb = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    rd(STATUS_A, v);
    check_eq("status_idle", v, 32'h4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_rdata", mem_rdata, 32'h0);
    check_eq("rst_txd", uart_txd, 1);
    tick(1);
    rst = 1'b0;
    rd(STATUS_A, v);
    check_eq("status_after_rst", v, 32'h4);

    wr(DATA_A, 32'h0000_00A5, 4'hF);
    exp_q.push_back(8'hA5);
    tick(5);
    rd(STATUS_A, v);
    check_eq("status_busy", v, 32'h5);
    wait_drain();
    rd(STATUS_A, v);
    check_eq("status_done", v, 32'h4);

    for (int i = 1; i <= 5; i++) begin
      wr(DATA_A, 32'(i * 8'h11), 4'h1);
      exp_q.push_back(8'(i * 8'h11));
    end
    rd(STATUS_A, v);
    check_eq("status_full", v, 32'h3);
    wr(DATA_A, 32'h66, 4'h1);
    rd(STATUS_A, v);
    check_eq("status_ovf", v, 32'hB);
    wr(STATUS_A, 32'h8, 4'hF);
    rd(STATUS_A, v);
    check_eq("status_ovf_clr", v, 32'h3);
    tick(3);
    check_eq("rdata_hold", mem_rdata, 32'h3);
    rd(32'h0000_0010, v);
    check_eq("rd_sel0", v, 32'h0);
    rd(STATUS_A, v);
    check_eq("status_again", v, 32'h3);
    rd(OFF2_A, v);
    check_eq("rd_off2", v, 32'h0);
    rd(STATUS_A, v);
    rd(DATA_A, v);
    check_eq("rd_data_reg", v, 32'h0);
    wait_drain();

    // Writes that must not enqueue anything
    wr(OFF2_A, 32'hFF, 4'hF);
    wr(32'h0000_0000, 32'h77, 4'hF);
    wr(DATA_A, 32'h88, 4'b0010);
    tick(60);
    wait_drain();
    rd(STATUS_A, v);
    check_eq("status_ignored_wr", v, 32'h4);

    wr(DATA_A, 32'h07, 4'h1);
    exp_q.push_back(8'h07);
    wr(DATA_A, 32'h03, 4'h1);
    exp_q.push_back(8'h03);
    wait_drain();
    rd(STATUS_A, v);
    check_eq("status_end", v, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
